// File: rtl/riesgos_pkg.sv
// Shared types and constants for the hazard/forwarding controller: forwarding
// select encodings and the shadow pipeline-stage entry.
package riesgos_pkg;

  localparam int RIESGOS_AW  = 5;
  localparam int RIESGOS_NRD = 2;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  typedef struct packed {
    logic                                    valid;
    logic [RIESGOS_AW-1:0]                   rd;
    logic                                    regwrite;
    logic                                    memread;
    logic [RIESGOS_NRD-1:0][RIESGOS_AW-1:0]  rs;
    logic [RIESGOS_NRD-1:0]                  rs_used;
  } entrada_t;

  localparam entrada_t BURBUJA = '0;

endpackage

// File: rtl/unidad_riesgos_if.sv
// Bundle between the datapath (master) and the hazard unit (slave): ID-stage
// metadata and branch outcome in, enables/flushes/forward selects out.
interface unidad_riesgos_if #(
  parameter int REG_AW = 5,
  parameter int NRD    = 2,
  parameter int CNT_W  = 16
);
  logic                    id_valid;
  logic [NRD*REG_AW-1:0]   id_rs;
  logic [NRD-1:0]          id_rs_used;
  logic [REG_AW-1:0]       id_rd;
  logic                    id_regwrite;
  logic                    id_memread;
  logic                    br_taken;

  logic                    pc_en;
  logic                    ifid_en;
  logic                    ifid_flush;
  logic                    idex_flush;
  logic                    exmem_flush;
  logic [2*NRD-1:0]        ex_fwd;
  logic [NRD-1:0]          id_bypass_wb;
  logic [CNT_W-1:0]        stall_cnt;
  logic [CNT_W-1:0]        flush_cnt;

  modport master (
    output id_valid, id_rs, id_rs_used, id_rd, id_regwrite, id_memread, br_taken,
    input  pc_en, ifid_en, ifid_flush, idex_flush, exmem_flush, ex_fwd,
           id_bypass_wb, stall_cnt, flush_cnt
  );

  modport slave (
    input  id_valid, id_rs, id_rs_used, id_rd, id_regwrite, id_memread, br_taken,
    output pc_en, ifid_en, ifid_flush, idex_flush, exmem_flush, ex_fwd,
           id_bypass_wb, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/comparador_dep.sv
// Flags whether one source operand reads the register written by one stage;
// register 0 and non-writing stages never produce a dependency.
module comparador_dep #(
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] rs,
  input  logic              rs_used,
  input  logic              valid,
  input  logic              regwrite,
  input  logic [REG_AW-1:0] rd,
  output logic              dep
);

  always_comb begin
    dep = rs_used && valid && regwrite && (rd != '0) && (rd == rs);
  end

endmodule

// File: rtl/unidad_riesgos.sv
// Hazard/forwarding controller for the 5-stage pipeline: tracks EX/MEM/WB
// register metadata and derives stalls, flushes, forward selects and WB bypass.
module unidad_riesgos
  import riesgos_pkg::*;
#(
  parameter int REG_AW = RIESGOS_AW,
  parameter int NRD    = RIESGOS_NRD,
  parameter int FWD_EN = 1,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  unidad_riesgos_if.slave   bus
);

  if (REG_AW != RIESGOS_AW || NRD != RIESGOS_NRD) begin : g_chk_dim
    $error("unidad_riesgos: REG_AW/NRD must match the riesgos_pkg entry layout");
  end

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  entrada_t ex_q, ex_d;
  entrada_t mem_q, mem_d;
  entrada_t wb_q, wb_d;
  entrada_t id_ent;

  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic [NRD-1:0] dep_id_ex, dep_id_mem, dep_id_wb;
  logic [NRD-1:0] dep_ex_mem, dep_ex_wb;
  logic           hazard, stall, flush;
  logic           unused_wb;

  // The WB entry is only consulted for its destination register.
  assign unused_wb = ^{wb_q.memread, wb_q.rs, wb_q.rs_used};

  always_comb begin
    id_ent          = BURBUJA;
    id_ent.valid    = bus.id_valid;
    id_ent.rd       = bus.id_rd;
    id_ent.regwrite = bus.id_regwrite;
    id_ent.memread  = bus.id_memread;
    id_ent.rs_used  = bus.id_rs_used;
    for (int k = 0; k < NRD; k++) begin
      id_ent.rs[k] = bus.id_rs[k*REG_AW +: REG_AW];
    end
  end

  for (genvar k = 0; k < NRD; k++) begin : g_op
    comparador_dep #(.REG_AW(REG_AW)) u_id_ex (
      .rs(bus.id_rs[k*REG_AW +: REG_AW]), .rs_used(bus.id_rs_used[k]),
      .valid(ex_q.valid), .regwrite(ex_q.regwrite), .rd(ex_q.rd),
      .dep(dep_id_ex[k])
    );
    comparador_dep #(.REG_AW(REG_AW)) u_id_mem (
      .rs(bus.id_rs[k*REG_AW +: REG_AW]), .rs_used(bus.id_rs_used[k]),
      .valid(mem_q.valid), .regwrite(mem_q.regwrite), .rd(mem_q.rd),
      .dep(dep_id_mem[k])
    );
    comparador_dep #(.REG_AW(REG_AW)) u_id_wb (
      .rs(bus.id_rs[k*REG_AW +: REG_AW]), .rs_used(bus.id_rs_used[k]),
      .valid(wb_q.valid), .regwrite(wb_q.regwrite), .rd(wb_q.rd),
      .dep(dep_id_wb[k])
    );
    comparador_dep #(.REG_AW(REG_AW)) u_ex_mem (
      .rs(ex_q.rs[k]), .rs_used(ex_q.rs_used[k]),
      .valid(mem_q.valid), .regwrite(mem_q.regwrite), .rd(mem_q.rd),
      .dep(dep_ex_mem[k])
    );
    comparador_dep #(.REG_AW(REG_AW)) u_ex_wb (
      .rs(ex_q.rs[k]), .rs_used(ex_q.rs_used[k]),
      .valid(wb_q.valid), .regwrite(wb_q.regwrite), .rd(wb_q.rd),
      .dep(dep_ex_wb[k])
    );
  end

  // Flush beats stall; reset masks both so outputs take their idle values at once.
  always_comb begin
    flush = bus.br_taken & ~rst;
    if (FWD_EN != 0) begin
      hazard = (|dep_id_ex) & ex_q.memread;
    end else begin
      hazard = |(dep_id_ex | dep_id_mem);
    end
    stall = hazard & bus.id_valid & ~flush & ~rst;
  end

  always_comb begin
    bus.pc_en        = ~stall;
    bus.ifid_en      = ~stall;
    bus.ifid_flush   = flush;
    bus.idex_flush   = flush;
    bus.exmem_flush  = flush;
    bus.id_bypass_wb = dep_id_wb;
    bus.ex_fwd       = {NRD{FWD_RF}};
    if (FWD_EN != 0) begin
      for (int k = 0; k < NRD; k++) begin
        if (dep_ex_mem[k]) begin
          bus.ex_fwd[2*k +: 2] = FWD_MEM;
        end else if (dep_ex_wb[k]) begin
          bus.ex_fwd[2*k +: 2] = FWD_WB;
        end
      end
    end
    bus.stall_cnt = stall_cnt_q;
    bus.flush_cnt = flush_cnt_q;
  end

  always_comb begin
    wb_d        = mem_q;
    mem_d       = flush ? BURBUJA : ex_q;
    ex_d        = (stall || flush) ? BURBUJA : id_ent;
    stall_cnt_d = stall ? sat_inc(stall_cnt_q) : stall_cnt_q;
    flush_cnt_d = flush ? sat_inc(flush_cnt_q) : flush_cnt_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_q        <= BURBUJA;
      mem_q       <= BURBUJA;
      wb_q        <= BURBUJA;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      ex_q        <= ex_d;
      mem_q       <= mem_d;
      wb_q        <= wb_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

endmodule

// File: tb/tb_unidad_riesgos.sv
// Directed bench: one forwarding-mode unit with 2-bit counters and one
// no-forwarding unit share the same ID/branch stimulus.
module tb_unidad_riesgos;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       id_valid = 1'b0;
  logic [4:0] rs1_v = '0, rs0_v = '0, rd_v = '0;
  logic [1:0] used_v = '0;
  logic       rw_v = 1'b0, mr_v = 1'b0, br_v = 1'b0;

  int n_pass = 0;
  int n_tot  = 0;

  always #5 clk = ~clk;

  unidad_riesgos_if #(.REG_AW(5), .NRD(2), .CNT_W(2))  ifa ();
  unidad_riesgos_if #(.REG_AW(5), .NRD(2), .CNT_W(16)) ifb ();

  assign ifa.id_valid    = id_valid;
  assign ifa.id_rs       = {rs1_v, rs0_v};
  assign ifa.id_rs_used  = used_v;
  assign ifa.id_rd       = rd_v;
  assign ifa.id_regwrite = rw_v;
  assign ifa.id_memread  = mr_v;
  assign ifa.br_taken    = br_v;
  assign ifb.id_valid    = id_valid;
  assign ifb.id_rs       = {rs1_v, rs0_v};
  assign ifb.id_rs_used  = used_v;
  assign ifb.id_rd       = rd_v;
  assign ifb.id_regwrite = rw_v;
  assign ifb.id_memread  = mr_v;
  assign ifb.br_taken    = br_v;

  unidad_riesgos #(.REG_AW(5), .NRD(2), .FWD_EN(1), .CNT_W(2)) dut_a (
    .clk(clk), .rst(rst), .bus(ifa.slave)
  );
  unidad_riesgos #(.REG_AW(5), .NRD(2), .FWD_EN(0), .CNT_W(16)) dut_b (
    .clk(clk), .rst(rst), .bus(ifb.slave)
  );

  typedef struct {
    logic       rst_b;
    logic       v;
    logic [4:0] rs1, rs0;
    logic [1:0] used;
    logic [4:0] rd;
    logic       rw, mr, br;
    logic       pc, fl;
    logic [3:0] fwd;
    logic [1:0] byp;
    logic [1:0] sc, fc;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic rst_b, logic v, logic [4:0] rs1, logic [4:0] rs0,
                              logic [1:0] used, logic [4:0] rd, logic rw, logic mr,
                              logic br, logic pc, logic fl, logic [3:0] fwd,
                              logic [1:0] byp, logic [1:0] sc, logic [1:0] fc);
    vec_t r;
    r.rst_b = rst_b; r.v = v; r.rs1 = rs1; r.rs0 = rs0; r.used = used; r.rd = rd;
    r.rw = rw; r.mr = mr; r.br = br; r.pc = pc; r.fl = fl; r.fwd = fwd;
    r.byp = byp; r.sc = sc; r.fc = fc;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else n_pass++;
  endtask

  task automatic drive(input logic v, input logic [4:0] rs1, input logic [4:0] rs0,
                       input logic [1:0] used, input logic [4:0] rd, input logic rw,
                       input logic mr, input logic br);
    id_valid = v; rs1_v = rs1; rs0_v = rs0; used_v = used; rd_v = rd;
    rw_v = rw; mr_v = mr; br_v = br;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // forwarding MEM then WB
    tbl.push_back(mk(1, 1, 0, 0, 2'b00, 3, 1, 0, 0,  1, 0, 4'b0000, 2'b00, 0, 0));
    tbl.push_back(mk(0, 1, 0, 3, 2'b01, 4, 1, 0, 0,  1, 0, 4'b0000, 2'b00, 0, 0));
    tbl.push_back(mk(0, 1, 3, 0, 2'b10, 5, 1, 0, 0,  1, 0, 4'b0001, 2'b00, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 2'b00, 0, 0, 0, 0,  1, 0, 4'b1000, 2'b00, 0, 0));
    // load-use
    tbl.push_back(mk(1, 1, 0, 0, 2'b00, 5, 1, 1, 0,  1, 0, 4'b0000, 2'b00, 0, 0));
    tbl.push_back(mk(0, 1, 0, 5, 2'b01, 6, 1, 0, 0,  0, 0, 4'b0000, 2'b00, 0, 0));
    tbl.push_back(mk(0, 1, 0, 5, 2'b01, 6, 1, 0, 0,  1, 0, 4'b0000, 2'b00, 1, 0));
    tbl.push_back(mk(0, 1, 5, 0, 2'b10, 0, 0, 0, 0,  1, 0, 4'b0010, 2'b10, 1, 0));
    // branch flush
    tbl.push_back(mk(1, 1, 0, 0, 2'b00, 6, 1, 0, 0,  1, 0, 4'b0000, 2'b00, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 2'b00, 7, 1, 0, 1,  1, 1, 4'b0000, 2'b00, 0, 0));
    tbl.push_back(mk(0, 1, 0, 6, 2'b01, 0, 0, 0, 0,  1, 0, 4'b0000, 2'b00, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 2'b00, 0, 0, 0, 0,  1, 0, 4'b0000, 2'b00, 0, 1));
    // register 0, unused operands, load-use hidden by a flush
    tbl.push_back(mk(1, 1, 0, 0, 2'b00, 0, 1, 1, 0,  1, 0, 4'b0000, 2'b00, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 2'b01, 1, 1, 0, 0,  1, 0, 4'b0000, 2'b00, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 2'b00, 7, 1, 1, 0,  1, 0, 4'b0000, 2'b00, 0, 0));
    tbl.push_back(mk(0, 1, 7, 7, 2'b00, 2, 1, 0, 0,  1, 0, 4'b0000, 2'b00, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 2'b00, 8, 1, 1, 0,  1, 0, 4'b0000, 2'b00, 0, 0));
    tbl.push_back(mk(0, 1, 0, 8, 2'b01, 9, 1, 0, 1,  1, 1, 4'b0000, 2'b00, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 2'b00, 0, 0, 0, 0,  1, 0, 4'b0000, 2'b00, 0, 1));

    // reset state, with a branch and a would-be hazard on the inputs
    drive(1, 3, 3, 2'b11, 3, 1, 1, 1);
    #2;
    chk("rst_pc_en",     {31'd0, ifa.pc_en},       32'd1);
    chk("rst_ifid_en",   {31'd0, ifa.ifid_en},     32'd1);
    chk("rst_flushes",   {29'd0, ifa.ifid_flush, ifa.idex_flush, ifa.exmem_flush}, 32'd0);
    chk("rst_ex_fwd",    {28'd0, ifa.ex_fwd},      32'd0);
    chk("rst_bypass",    {30'd0, ifa.id_bypass_wb}, 32'd0);
    chk("rst_stall_cnt", {30'd0, ifa.stall_cnt},   32'd0);
    chk("rst_flush_cnt", {30'd0, ifa.flush_cnt},   32'd0);
    drive(0, 0, 0, 2'b00, 0, 0, 0, 0);
    do_reset();

    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].rst_b) do_reset();
      drive(tbl[i].v, tbl[i].rs1, tbl[i].rs0, tbl[i].used, tbl[i].rd,
            tbl[i].rw, tbl[i].mr, tbl[i].br);
      @(negedge clk);
      chk($sformatf("v%0d_pc_en", i),   {31'd0, ifa.pc_en},   {31'd0, tbl[i].pc});
      chk($sformatf("v%0d_ifid_en", i), {31'd0, ifa.ifid_en}, {31'd0, tbl[i].pc});
      chk($sformatf("v%0d_flushes", i),
          {29'd0, ifa.ifid_flush, ifa.idex_flush, ifa.exmem_flush}, {29'd0, {3{tbl[i].fl}}});
      chk($sformatf("v%0d_ex_fwd", i),    {28'd0, ifa.ex_fwd},       {28'd0, tbl[i].fwd});
      chk($sformatf("v%0d_bypass", i),    {30'd0, ifa.id_bypass_wb}, {30'd0, tbl[i].byp});
      chk($sformatf("v%0d_stall_cnt", i), {30'd0, ifa.stall_cnt},    {30'd0, tbl[i].sc});
      chk($sformatf("v%0d_flush_cnt", i), {30'd0, ifa.flush_cnt},    {30'd0, tbl[i].fc});
      chk($sformatf("v%0d_nofwd_ex_fwd", i), {28'd0, ifb.ex_fwd}, 32'd0);
      step();
    end

    // no-forwarding mode: RAW stall until the producer reaches WB
    do_reset();
    drive(1, 0, 0, 2'b00, 4, 1, 0, 0);
    @(negedge clk);
    chk("nf_producer_pc_en", {31'd0, ifb.pc_en}, 32'd1);
    step();
    drive(1, 0, 4, 2'b01, 5, 1, 0, 0);
    @(negedge clk);
    chk("nf_stall1_pc_en",   {31'd0, ifb.pc_en},   32'd0);
    chk("nf_stall1_ifid_en", {31'd0, ifb.ifid_en}, 32'd0);
    step();
    @(negedge clk);
    chk("nf_stall2_pc_en",   {31'd0, ifb.pc_en},   32'd0);
    step();
    @(negedge clk);
    chk("nf_issue_pc_en",    {31'd0, ifb.pc_en},        32'd1);
    chk("nf_issue_bypass",   {30'd0, ifb.id_bypass_wb}, 32'd1);
    chk("nf_stall_cnt",      ifb.stall_cnt,             32'd2);
    step();

    // five load-use stalls saturate a 2-bit counter
    do_reset();
    for (int n = 0; n < 5; n++) begin
      drive(1, 0, 0, 2'b00, 9, 1, 1, 0);
      step();
      drive(1, 0, 9, 2'b01, 10, 1, 0, 0);
      @(negedge clk);
      chk($sformatf("sat_stall%0d_pc_en", n), {31'd0, ifa.pc_en}, 32'd0);
      step();
      step();
    end
    drive(0, 0, 0, 2'b00, 0, 0, 0, 0);
    @(negedge clk);
    chk("sat_stall_cnt", {30'd0, ifa.stall_cnt}, 32'd3);
    step();

    // reset in the middle of a stall
    drive(0, 0, 0, 2'b00, 0, 0, 0, 1);
    step();
    drive(1, 0, 0, 2'b00, 10, 1, 1, 0);
    step();
    drive(1, 0, 10, 2'b01, 11, 1, 0, 0);
    @(negedge clk);
    chk("mid_stall_pc_en",   {31'd0, ifa.pc_en},     32'd0);
    chk("mid_flush_cnt",     {30'd0, ifa.flush_cnt}, 32'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_pc_en",     {31'd0, ifa.pc_en},     32'd1);
    chk("mid_rst_ifid_en",   {31'd0, ifa.ifid_en},   32'd1);
    chk("mid_rst_stall_cnt", {30'd0, ifa.stall_cnt}, 32'd0);
    chk("mid_rst_flush_cnt", {30'd0, ifa.flush_cnt}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_no_dep",   {31'd0, ifa.pc_en},        32'd1);
    chk("post_rst_bypass",   {30'd0, ifa.id_bypass_wb}, 32'd0);
    step();

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
